// File: rtl/heap_sort5_core.sv
// heap_sort5_core: sequential heap sort of five 32-bit unsigned values.
// A max-heap is built in place, then the root is repeatedly swapped to the
// tail and re-sifted. One sift step or one swap runs per cycle. The sorted
// vector is emitted as a single-cycle tagged result.
module heap_sort5_core (
  input  logic         system1000,
  input  logic         system1000_rstn,
  input  logic [160:0] eta_i1,
  output logic [160:0] topLet_o
);

  typedef enum logic [2:0] {S_IDLE, S_BUILD, S_SWAP, S_SIFT, S_OUT} state_e;

  state_e           state_q, state_d;
  logic [4:0][31:0] a_q, a_d;
  logic [2:0]       k_q, k_d;
  logic [2:0]       m_q, m_d;
  logic             phase_q, phase_d;   // build: 0 = sifting node 1, 1 = node 0
  logic [160:0]     res_q, res_d;

  logic [3:0] l_idx, r_idx;
  logic       l_ok, r_ok;
  logic [2:0] sel;
  logic       sift_done;
  logic [2:0] end_idx;

  // Sift step: pick the largest of node and its in-heap children, ties keep
  // the node, then the left child. The sift ends when nothing moves or the
  // moved-to node has no child inside the heap.
  always_comb begin
    l_idx = {k_q, 1'b1};
    r_idx = l_idx + 4'd1;
    l_ok  = l_idx < {1'b0, m_q};
    r_ok  = r_idx < {1'b0, m_q};
    sel   = k_q;
    if (l_ok && (a_q[l_idx[2:0]] > a_q[sel])) sel = l_idx[2:0];
    if (r_ok && (a_q[r_idx[2:0]] > a_q[sel])) sel = r_idx[2:0];
    sift_done = (sel == k_q) || ({sel, 1'b1} >= {1'b0, m_q});
    end_idx   = m_q - 3'd1;
  end

  // State register
  always_ff @(posedge system1000 or posedge system1000_rstn) begin
    if (system1000_rstn) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state: build two sifts, then swap/sift until the heap holds one
  // element; the final sift over a one-element heap is empty, so the last
  // swap goes straight to OUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (eta_i1[160]) state_d = S_BUILD;
      S_BUILD: if (sift_done && phase_q) state_d = S_SWAP;
      S_SWAP:  state_d = (end_idx == 3'd1) ? S_OUT : S_SIFT;
      S_SIFT:  if (sift_done) state_d = S_SWAP;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output: load, sift swaps, root-to-tail swaps, result capture.
  always_comb begin
    a_d     = a_q;
    k_d     = k_q;
    m_d     = m_q;
    phase_d = phase_q;
    res_d   = {1'b0, res_q[159:0]};
    case (state_q)
      S_IDLE: begin
        if (eta_i1[160]) begin
          for (int i = 0; i < 5; i++) a_d[i] = eta_i1[159-32*i -: 32];
          k_d     = 3'd1;
          m_d     = 3'd5;
          phase_d = 1'b0;
        end
      end
      S_BUILD, S_SIFT: begin
        if (sel != k_q) begin
          a_d[k_q] = a_q[sel];
          a_d[sel] = a_q[k_q];
          k_d      = sel;
        end
        if (sift_done && (state_q == S_BUILD) && !phase_q) begin
          k_d     = 3'd0;
          phase_d = 1'b1;
        end
      end
      S_SWAP: begin
        a_d[0]       = a_q[end_idx];
        a_d[end_idx] = a_q[0];
        m_d          = end_idx;
        k_d          = 3'd0;
      end
      S_OUT: begin
        res_d = {1'b1, a_q[0], a_q[1], a_q[2], a_q[3], a_q[4]};
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge system1000 or posedge system1000_rstn) begin
    if (system1000_rstn) begin
      a_q     <= '0;
      k_q     <= '0;
      m_q     <= '0;
      phase_q <= 1'b0;
      res_q   <= '0;
    end else begin
      a_q     <= a_d;
      k_q     <= k_d;
      m_q     <= m_d;
      phase_q <= phase_d;
      res_q   <= res_d;
    end
  end

  assign topLet_o = res_q;

endmodule

// File: tb/tb_heap_sort5_core.sv
// tb_heap_sort5_core: table-driven sort vectors plus hand-written sequences
// for reset, busy-ignore, back-to-back and untagged input; a queue
// scoreboard matches every result pulse to an accepted batch.
module tb_heap_sort5_core;

  logic         clk;
  logic         rst;
  logic [160:0] eta;
  logic [160:0] top;

  heap_sort5_core dut (
    .system1000      (clk),
    .system1000_rstn (rst),
    .eta_i1          (eta),
    .topLet_o        (top)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] in;
    logic [159:0] exp;
  } vec_t;

  typedef struct {
    logic [159:0] exp;
    int           acc;
  } sb_t;

  sb_t          q[$];
  vec_t         tbl[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [159:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [159:0] pk(input logic [31:0] e0, e1, e2, e3, e4);
    return {e0, e1, e2, e3, e4};
  endfunction

  // Reference: plain bubble sort, ascending.
  function automatic logic [159:0] ref_sort(input logic [159:0] v);
    logic [31:0] e[5];
    logic [31:0] t;
    for (int i = 0; i < 5; i++) e[i] = v[159-32*i -: 32];
    for (int p = 0; p < 4; p++)
      for (int j = 0; j < 4 - p; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    return pk(e[0], e[1], e[2], e[3], e[4]);
  endfunction

  task automatic chk(input string name, input logic [160:0] act, input logic [160:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every pulse must match the oldest accepted batch, in data
  // and in latency from the accepting edge.
  always @(negedge clk) begin
    if (!rst && top[160]) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%h required=no_pulse", top);
      end else begin
        sb_t e;
        int  lat;
        e = q.pop_front();
        chk("result", top, {1'b1, e.exp});
        lat = cyc - e.acc;
        checks++;
        if (lat < 10 || lat > 12) begin
          failures++;
          $display("FAIL latency actual=%0d required=10..12", lat);
        end
        last_exp = e.exp;
      end
    end
  end

  // Present a tagged vector for one accepting edge, then drop the tag.
  task automatic send(input logic [159:0] v, input logic [159:0] exp);
    @(negedge clk);
    eta = {1'b1, v};
    @(posedge clk);
    #1;
    q.push_back('{exp: exp, acc: cyc});
    eta = {1'b0, ~v};
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=pending required=result", name);
      q.delete();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [159:0] v;
    rst = 1'b1;
    eta = '0;

    tbl.push_back('{in: pk(5, 3, 9, 1, 7), exp: pk(1, 3, 5, 7, 9)});
    tbl.push_back('{in: pk(1, 2, 3, 4, 5), exp: pk(1, 2, 3, 4, 5)});
    tbl.push_back('{in: pk(5, 4, 3, 2, 1), exp: pk(1, 2, 3, 4, 5)});
    tbl.push_back('{in: pk(32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 32'h80000000),
                    exp: pk(0, 0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF)});
    tbl.push_back('{in: pk(7, 7, 7, 7, 7), exp: pk(7, 7, 7, 7, 7)});
    tbl.push_back('{in: pk(2, 9, 2, 9, 2), exp: pk(2, 2, 2, 9, 9)});
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 5; j++)
        v[159-32*j -: 32] = (i < 3) ? 32'($urandom_range(0, 3)) : $urandom;
      tbl.push_back('{in: v, exp: ref_sort(v)});
    end

    // Reset state
    #1;
    chk("reset_out", top, '0);
    idle(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_zero", top, '0);
    end

    // Table-driven sorts
    foreach (tbl[i]) begin
      send(tbl[i].in, tbl[i].exp);
      wait_done("sort");
      idle(2);
    end

    // Untagged input: no pulse, data held
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      eta = {1'b0, 32'($urandom), 128'(i)};
      @(negedge clk);
      chk("untagged_hold", top, {1'b0, last_exp});
    end
    eta = '0;

    // Busy ignore, then back-to-back acceptance of a held tagged vector
    send(pk(40, 10, 30, 50, 20), pk(10, 20, 30, 40, 50));
    idle(2);
    eta = {1'b1, pk(1, 1, 1, 1, 1)};
    @(negedge clk);
    eta = '0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("busy_first", {1'b0, last_exp}, {1'b0, pk(10, 20, 30, 40, 50)});
    eta = {1'b1, pk(6, 8, 4, 2, 0)};
    q.push_back('{exp: pk(0, 2, 4, 6, 8), acc: cyc + 1});
    idle(4);
    eta = '0;
    wait_done("b2b");
    idle(3);
    chk("b2b_data", {1'b0, last_exp}, {1'b0, pk(0, 2, 4, 6, 8)});

    // Reset mid-sort aborts the batch
    send(pk(3, 1, 4, 1, 5), pk(1, 1, 3, 4, 5));
    idle(4);
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", top, '0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_zero", top, '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
